bin_accum: RTL



---
 rtl/bnn_pkg.sv | 13 +
 rtl/bin_accum_if.sv | 28 ++
 rtl/bin_decode.sv | 19 +
 rtl/bin_accum.sv | 113 +++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized datapath: the bipolar code points
// and the accumulator state machine encoding.
package bnn_pkg;

    localparam logic [1:0] BIN_POS = 2'b01;
    localparam logic [1:0] BIN_NEG = 2'b11;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_accum_if.sv
// Beat stream in (binarized codes) and result stream out (per-lane sums)
// for the de-binarizing accumulator.
interface bin_accum_if #(
    parameter int depth        = 32,
    parameter int target_depth = 2,
    parameter int WIDTH        = 3,
    parameter int LEN          = 16
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic                                      in_last;
    logic [WIDTH-1:0][target_depth-1:0]        data_binarized;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [WIDTH-1:0][depth-1:0]               data_out;
    logic [$clog2(LEN+1)-1:0]                  out_beats;
    logic                                      out_err;

    modport master (
        output in_valid, in_last, data_binarized, out_ready,
        input  in_ready, out_valid, data_out, out_beats, out_err
    );

    modport slave (
        input  in_valid, in_last, data_binarized, out_ready,
        output in_ready, out_valid, data_out, out_beats, out_err
    );
endinterface

// File: rtl/bin_decode.sv
// Maps one 2-bit bipolar code to a signed value (+1 / -1 / 0) and flags
// the two code points the binarizer never produces.
module bin_decode
    import bnn_pkg::*;
(
    input  logic [1:0]        code,
    output logic signed [1:0] val,
    output logic              invalid
);
    always_comb begin
        val     = 2'sb00;
        invalid = 1'b0;
        case (code)
            BIN_POS: val = 2'sb01;
            BIN_NEG: val = 2'sb11;
            default: invalid = 1'b1;
        endcase
    end
endmodule

// File: rtl/bin_accum.sv
// Streaming de-binarizer: sums WIDTH lanes of bipolar codes over a vector of
// up to LEN beats and presents one signed sum per lane with a beat count.
module bin_accum
    import bnn_pkg::*;
#(
    parameter int depth        = 32,
    parameter int target_depth = 2,
    parameter int WIDTH        = 3,
    parameter int LEN          = 16
) (
    input logic       clk,
    input logic       rst_n,
    bin_accum_if.slave bus
);
    localparam int CW = $clog2(LEN + 1);

    if (target_depth != 2 || LEN < 1 || depth < $clog2(LEN + 1) + 1) begin : g_bad_cfg
        $error("bin_accum: illegal parameter combination");
    end

    function automatic logic signed [depth-1:0] sext2(input logic signed [1:0] v);
        return {{(depth-2){v[1]}}, v};
    endfunction

    state_t                   state_q, state_d;
    logic signed [1:0]        dec_val [WIDTH];
    logic [WIDTH-1:0]         dec_inv;
    logic signed [depth-1:0]  acc_q   [WIDTH];
    logic signed [depth-1:0]  sum_d   [WIDTH];
    logic signed [depth-1:0]  dout_q  [WIDTH];
    logic [CW-1:0]            cnt_q, cnt_d, beats_q;
    logic                     err_q, err_d, oerr_q;
    logic                     accept, close, release_out;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        bin_decode u_dec (
            .code    (bus.data_binarized[g]),
            .val     (dec_val[g]),
            .invalid (dec_inv[g])
        );
        assign bus.data_out[g] = dout_q[g];
    end

    // Decoded beat folded into the running sums; used both to update the
    // accumulators and to latch the result on the closing beat.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i] = acc_q[i] + sext2(dec_val[i]);
        end
        cnt_d = cnt_q + CW'(1);
        err_d = err_q | (|dec_inv);
    end

    assign accept      = bus.in_valid & (state_q == ACC);
    assign close       = accept & (bus.in_last | (cnt_d == CW'(LEN)));
    assign release_out = (state_q == OUT) & bus.out_ready;

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_beats = beats_q;
    assign bus.out_err   = oerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (close) state_d = OUT;
            OUT:     if (bus.out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Accumulators clear only on the output handshake, so a vector closed by
    // the LEN limit and one closed by in_last behave identically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                acc_q[i]  <= '0;
                dout_q[i] <= '0;
            end
            cnt_q   <= '0;
            err_q   <= 1'b0;
            beats_q <= '0;
            oerr_q  <= 1'b0;
        end else if (release_out) begin
            for (int i = 0; i < WIDTH; i++) begin
                acc_q[i] <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                acc_q[i] <= sum_d[i];
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (close) begin
                for (int i = 0; i < WIDTH; i++) begin
                    dout_q[i] <= sum_d[i];
                end
                beats_q <= cnt_d;
                oerr_q  <= err_d;
            end
        end
    end
endmodule
